rs232tx: RTL and testbench

RS232TX -- requirements
Module: rs232tx

---
 rtl/rs232tx_if.sv | 28 ++
 rtl/rs232tx.sv | 185 ++++++++++++++++++
 tb/tb_rs232tx.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs232tx_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rs232tx_if : byte-write / serial-status bundle for rs232tx   | rev 1.0   |
// +--------------------------------------------------------------------------+
interface rs232tx_if #(
    parameter int FIFO_LOG2 = 4
);
    logic [7:0]         transmit_data;
    logic               we;
    logic [1:0]         parity_mode;
    logic               two_stop;
    logic               serial_out;
    logic               full;
    logic               busy;
    logic [FIFO_LOG2:0] level;
    logic               overrun;

    modport master (
        output transmit_data, we, parity_mode, two_stop,
        input  serial_out, full, busy, level, overrun
    );

    modport slave (
        input  transmit_data, we, parity_mode, two_stop,
        output serial_out, full, busy, level, overrun
    );
endinterface
`default_nettype wire

// File: rtl/rs232tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rs232tx : FIFO-buffered asynchronous serial transmitter     | rev 1.0   |
// +--------------------------------------------------------------------------+
module rs232tx #(
    parameter int PERIOD    = 434,
    parameter int DATA_BITS = 8,
    parameter int FIFO_LOG2 = 4
) (
    input  wire logic   clock,
    input  wire logic   reset_n,
    rs232tx_if.slave    bus
);
    localparam int                   c_DEPTH      = 1 << FIFO_LOG2;
    localparam int                   c_LW         = FIFO_LOG2 + 1;
    localparam logic [c_LW-1:0]      c_FULL_LEVEL = c_LW'(c_DEPTH);
    localparam logic [15:0]          c_RELOAD     = 16'(PERIOD - 1);
    localparam logic [2:0]           c_LAST_BIT   = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // FIFO storage and bookkeeping
    logic [DATA_BITS-1:0] mem_q [c_DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_LW-1:0]      level_q, level_d;
    logic                 full_q;
    logic                 overrun_q;
    logic                 w_push;
    logic                 w_pop;
    logic [DATA_BITS-1:0] w_head;

    // Transmitter
    state_t               state_q;
    logic [15:0]          cnt_q;
    logic [2:0]           bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_en_q;
    logic                 par_bit_q;
    logic                 two_stop_q;
    logic                 second_stop_q;
    logic                 serial_q;

    // full is the registered flag, so a pop in the same cycle never frees a slot for a write
    assign w_push = bus.we && !full_q;
    assign w_pop  = (state_q == S_IDLE) && (level_q != '0);
    assign w_head = mem_q[rd_ptr_q];

    always_ff @(posedge clock) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= bus.transmit_data[DATA_BITS-1:0];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            full_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            full_q    <= (level_d == c_FULL_LEVEL);
            overrun_q <= bus.we && full_q;
        end
    end

    // The line register follows the state by one cycle, so every cell keeps its full length
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            par_en_q      <= 1'b0;
            par_bit_q     <= 1'b0;
            two_stop_q    <= 1'b0;
            second_stop_q <= 1'b0;
            serial_q      <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    serial_q <= 1'b1;
                    if (w_pop) begin
                        shift_q       <= w_head;
                        par_en_q      <= (bus.parity_mode == 2'b01) || (bus.parity_mode == 2'b10);
                        par_bit_q     <= (^w_head) ^ (bus.parity_mode == 2'b01);
                        two_stop_q    <= bus.two_stop;
                        second_stop_q <= 1'b0;
                        cnt_q         <= c_RELOAD;
                        state_q       <= S_START;
                    end
                end

                S_START: begin
                    serial_q <= 1'b0;
                    if (cnt_q == '0) begin
                        cnt_q     <= c_RELOAD;
                        bit_idx_q <= '0;
                        state_q   <= S_DATA;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                S_DATA: begin
                    serial_q <= shift_q[0];
                    if (cnt_q == '0) begin
                        cnt_q   <= c_RELOAD;
                        shift_q <= shift_q >> 1;
                        if (bit_idx_q == c_LAST_BIT) begin
                            state_q <= par_en_q ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                S_PARITY: begin
                    serial_q <= par_bit_q;
                    if (cnt_q == '0) begin
                        cnt_q   <= c_RELOAD;
                        state_q <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                S_STOP: begin
                    serial_q <= 1'b1;
                    if (cnt_q == '0) begin
                        if (two_stop_q && !second_stop_q) begin
                            second_stop_q <= 1'b1;
                            cnt_q         <= c_RELOAD;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                default: begin
                    serial_q <= 1'b1;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.serial_out = serial_q;
    assign bus.full       = full_q;
    assign bus.busy       = (state_q != S_IDLE) || (level_q != '0);
    assign bus.level      = level_q;
    assign bus.overrun    = overrun_q;
endmodule
`default_nettype wire

// File: tb/tb_rs232tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rs232tx : scoreboard bench, line-decoding monitor per DUT | rev 1.0   |
// +--------------------------------------------------------------------------+
module tb_rs232tx;
    localparam int P = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   wcyc  = 0;
    int   c     = 0;

    typedef struct {
        logic [7:0] data;
        int         nbits;
        bit         par_en;
        bit         par_bit;
        int         nstop;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   starts_a[$];
    int   starts_b[$];

    rs232tx_if #(.FIFO_LOG2(2)) ifa();
    rs232tx_if #(.FIFO_LOG2(2)) ifb();

    rs232tx #(.PERIOD(P), .DATA_BITS(8), .FIFO_LOG2(2)) dut_a (
        .clock(clk), .reset_n(rst_n), .bus(ifa)
    );
    rs232tx #(.PERIOD(P), .DATA_BITS(5), .FIFO_LOG2(2)) dut_b (
        .clock(clk), .reset_n(rst_n), .bus(ifb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic line_of(input int which);
        return (which == 0) ? ifa.serial_out : ifb.serial_out;
    endfunction

    function automatic logic busy_of(input int which);
        return (which == 0) ? ifa.busy : ifb.busy;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic push_exp(input int which, input logic [7:0] d, input int nb,
                            input bit pe, input bit pb, input int ns);
        exp_t e;
        e.data = d; e.nbits = nb; e.par_en = pe; e.par_bit = pb; e.nstop = ns;
        if (which == 0) q_a.push_back(e);
        else            q_b.push_back(e);
    endtask

    task automatic wr(input int which, input logic [7:0] d);
        if (which == 0) begin ifa.we = 1'b1; ifa.transmit_data = d; end
        else            begin ifb.we = 1'b1; ifb.transmit_data = d; end
        @(posedge clk); #1;
        wcyc   = cyc;
        ifa.we = 1'b0;
        ifb.we = 1'b0;
    endtask

    task automatic wait_idle(input int which, output int cend);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy_of(which) == 1'b1 && n < 3000);
        if (n >= 3000) begin
            total++; bad++;
            $display("FAIL idle_timeout dut%0d: busy=1 after %0d cycles, want 0", which, n);
        end
        cend = cyc;
    endtask

    task automatic check_cell(input int which, input logic exp, input int ncyc,
                              input string nm, output bit aborted);
        bit   err  = 1'b0;
        logic seen = exp;
        aborted = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (!rst_n) begin
                aborted = 1'b1;
                return;
            end
            if (line_of(which) !== exp) begin
                err  = 1'b1;
                seen = line_of(which);
            end
        end
        total++;
        if (err) begin
            bad++;
            $display("FAIL %s dut%0d: line=%b want=%b", nm, which, seen, exp);
        end
    endtask

    task automatic monitor(input int which);
        exp_t e;
        bit   have;
        bit   ab;
        forever begin
            @(negedge clk);
            if (rst_n && line_of(which) == 1'b0) begin
                if (which == 0) begin
                    starts_a.push_back(cyc);
                    have = (q_a.size() > 0);
                    if (have) e = q_a.pop_front();
                end else begin
                    starts_b.push_back(cyc);
                    have = (q_b.size() > 0);
                    if (have) e = q_b.pop_front();
                end
                if (!have) begin
                    total++; bad++;
                    $display("FAIL unexpected_frame dut%0d: start bit seen, want none", which);
                    for (int k = 0; k < 1000 && line_of(which) == 1'b0; k++) @(negedge clk);
                end else begin
                    check_cell(which, 1'b0, P - 1, $sformatf("start_%02h", e.data), ab);
                    for (int i = 0; i < e.nbits && !ab; i++)
                        check_cell(which, e.data[i], P, $sformatf("data%0d_%02h", i, e.data), ab);
                    if (!ab && e.par_en)
                        check_cell(which, e.par_bit, P, $sformatf("parity_%02h", e.data), ab);
                    for (int i = 0; i < e.nstop && !ab; i++)
                        check_cell(which, 1'b1, P, $sformatf("stop%0d_%02h", i, e.data), ab);
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ifa.we = 1'b0; ifa.transmit_data = '0; ifa.parity_mode = 2'b00; ifa.two_stop = 1'b0;
        ifb.we = 1'b0; ifb.transmit_data = '0; ifb.parity_mode = 2'b00; ifb.two_stop = 1'b0;

        // asynchronous reset before any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("rst_serial_out", ifa.serial_out, 1);
        chk("rst_level",      ifa.level,      0);
        chk("rst_full",       ifa.full,       0);
        chk("rst_busy",       ifa.busy,       0);
        chk("rst_overrun",    ifa.overrun,    0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 0x55, no parity, one stop; first write right after reset release
        starts_a.delete();
        push_exp(0, 8'h55, 8, 1'b0, 1'b0, 1);
        wr(0, 8'h55);
        chk("busy_after_write", ifa.busy, 1);
        wait_idle(0, c);
        chk("len_55", c - wcyc, 41);
        chk("latency_55", (starts_a.size() > 0) ? starts_a[0] - wcyc : -1, 2);

        // even then odd parity on 0x07
        ifa.parity_mode = 2'b10;
        push_exp(0, 8'h07, 8, 1'b1, 1'b1, 1);
        wr(0, 8'h07);
        wait_idle(0, c);
        chk("len_07_even", c - wcyc, 45);
        ifa.parity_mode = 2'b01;
        push_exp(0, 8'h07, 8, 1'b1, 1'b0, 1);
        wr(0, 8'h07);
        wait_idle(0, c);
        chk("len_07_odd", c - wcyc, 45);

        // mode 11 behaves as no parity
        ifa.parity_mode = 2'b11;
        push_exp(0, 8'hC3, 8, 1'b0, 1'b0, 1);
        wr(0, 8'hC3);
        wait_idle(0, c);
        chk("len_C3_mode11", c - wcyc, 41);

        // even parity with two stop bits
        ifa.parity_mode = 2'b10;
        ifa.two_stop    = 1'b1;
        push_exp(0, 8'h5A, 8, 1'b1, 1'b0, 2);
        wr(0, 8'h5A);
        wait_idle(0, c);
        chk("len_5A_even_2stop", c - wcyc, 49);
        ifa.parity_mode = 2'b00;
        ifa.two_stop    = 1'b0;

        // fill the 4-deep FIFO, sixth write overruns
        starts_a.delete();
        for (int i = 1; i <= 6; i++) begin
            if (i <= 5) push_exp(0, 8'(i), 8, 1'b0, 1'b0, 1);
            ifa.we = 1'b1;
            ifa.transmit_data = 8'(i);
            @(posedge clk); #1;
            if (i == 4) chk("full_after_4th", ifa.full, 0);
            if (i == 5) begin
                chk("full_after_5th",  ifa.full,  1);
                chk("level_after_5th", ifa.level, 4);
            end
        end
        ifa.we = 1'b0;
        chk("overrun_pulse",    ifa.overrun, 1);
        chk("level_after_drop", ifa.level,   4);
        @(posedge clk); #1;
        chk("overrun_one_cycle", ifa.overrun, 0);
        wait_idle(0, c);
        chk("fifo_frame_count", starts_a.size(), 5);
        if (starts_a.size() >= 5)
            for (int i = 1; i < 5; i++)
                chk($sformatf("b2b_gap_%0d", i), starts_a[i] - starts_a[i-1], 41);

        // 5 data bits, two stops; mode toggled mid-frame must not matter
        ifb.two_stop    = 1'b1;
        ifb.parity_mode = 2'b00;
        push_exp(1, 8'h1F, 5, 1'b0, 1'b0, 2);
        wr(1, 8'hFF);
        repeat (8) @(negedge clk);
        ifb.parity_mode = 2'b10;
        ifb.two_stop    = 1'b0;
        wait_idle(1, c);
        chk("len_5bit_2stop", c - wcyc, 33);
        ifb.parity_mode = 2'b00;

        // reset in the middle of a data bit with three bytes queued
        push_exp(0, 8'h11, 8, 1'b0, 1'b0, 1);
        wr(0, 8'h11);
        wr(0, 8'h22);
        wr(0, 8'h33);
        wr(0, 8'h44);
        chk("level_before_reset", ifa.level, 3);
        repeat (10) @(negedge clk);
        chk("line_in_data_bit1", ifa.serial_out, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_serial_out", ifa.serial_out, 1);
        chk("midrst_level",      ifa.level,      0);
        chk("midrst_busy",       ifa.busy,       0);
        chk("midrst_full",       ifa.full,       0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        q_a.delete();
        starts_a.delete();
        push_exp(0, 8'hA5, 8, 1'b0, 1'b0, 1);
        wr(0, 8'hA5);
        wait_idle(0, c);
        chk("len_A5_after_rst", c - wcyc, 41);
        chk("latency_A5", (starts_a.size() > 0) ? starts_a[0] - wcyc : -1, 2);

        repeat (4) @(negedge clk);
        chk("scoreboard_a_drained", q_a.size(), 0);
        chk("scoreboard_b_drained", q_b.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
